// File: rtl/image_stream_source.sv
// image_stream_source: frame-streaming pixel source with a per-frame point op.
// Fetches PIXELS_PER_CLK RGB888 pixels per memory word, applies pass /
// threshold / invert / brightness, and streams the beats through a 2-entry
// FIFO with VSYNC / LINE / HBLANK framing.
// Optional feature macro: IMG_BRIGHTNESS_EN (mode 11 adds a saturating
// brightness offset; when undefined, mode 11 behaves as pass).

// Per-pixel point operation, one instance per lane.
module image_stream_pixel_op #(
  parameter int                THRESHOLD  = 90,
  parameter logic signed [8:0] BRIGHTNESS = 9'sd50
) (
  input  logic [1:0]  mode,
  input  logic [23:0] pix_i,
  output logic [23:0] pix_o
);
  localparam logic [9:0] THR3 = 10'(3 * THRESHOLD);

  logic [9:0] sum;

`ifdef IMG_BRIGHTNESS_EN
  // Channel + offset in 10-bit signed space, clamped back to 0..255.
  function automatic logic [7:0] add_sat(input logic [7:0] c);
    logic signed [9:0] s;
    s = $signed({2'b00, c}) + $signed({BRIGHTNESS[8], BRIGHTNESS});
    if (s < 10'sd0)        add_sat = 8'h00;
    else if (s > 10'sd255) add_sat = 8'hFF;
    else                   add_sat = s[7:0];
  endfunction
`endif

  // Select the operation latched for this frame.
  always_comb begin
    sum   = 10'(pix_i[23:16]) + 10'(pix_i[15:8]) + 10'(pix_i[7:0]);
    pix_o = pix_i;
    case (mode)
      2'b01:   pix_o = (sum > THR3) ? 24'hFFFFFF : 24'h000000;
      2'b10:   pix_o = ~pix_i;
`ifdef IMG_BRIGHTNESS_EN
      2'b11:   pix_o = {add_sat(pix_i[23:16]), add_sat(pix_i[15:8]), add_sat(pix_i[7:0])};
`else
      2'b11:   pix_o = pix_i;
`endif
      default: pix_o = pix_i;
    endcase
  end
endmodule

module image_stream_source #(
  parameter int                IMAGE_WIDTH    = 768,
  parameter int                IMAGE_HEIGHT   = 512,
  parameter int                PIXELS_PER_CLK = 2,
  parameter int                STARTUP_DELAY  = 100,
  parameter int                HSYNC_DELAY    = 160,
  parameter int                THRESHOLD      = 90,
  parameter logic signed [8:0] BRIGHTNESS     = 9'sd50,
  parameter int                ADDR_WIDTH     = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  output logic                         mem_Rd_En,
  output logic [ADDR_WIDTH-1:0]        mem_Addr,
  input  logic [24*PIXELS_PER_CLK-1:0] mem_Data,
  output logic [24*PIXELS_PER_CLK-1:0] pixel_Data,
  output logic                         pixel_Valid,
  input  logic                         pixel_Ready,
  output logic                         vertical_Pulse,
  output logic                         horizontal_Pulse,
  output logic [15:0]                  line_Count,
  output logic                         done_Flag
);
  localparam int         DW        = 24 * PIXELS_PER_CLK;
  localparam logic [15:0] BEATS     = 16'(IMAGE_WIDTH / PIXELS_PER_CLK);
  localparam logic [15:0] LAST_BEAT = 16'(IMAGE_WIDTH / PIXELS_PER_CLK - 1);
  localparam logic [15:0] SD_LAST   = 16'(STARTUP_DELAY - 1);
  localparam logic [15:0] HD_LAST   = 16'(HSYNC_DELAY - 1);
  localparam logic [15:0] LAST_LINE = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_LINE, S_HBLANK, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             dly_q, dly_d;
  logic [15:0]             line_q, line_d;
  logic [15:0]             issue_q, issue_d;   // reads issued this line
  logic [15:0]             popc_q, popc_d;     // beats accepted this line
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              mode_q, mode_d;
  logic                    rd_pend_q, rd_pend_d; // read data arrives this cycle
  logic [1:0][DW-1:0]      fifo_q, fifo_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;

  logic                    pop;
  logic                    rd_en;
  logic [2:0]              occ;
  logic [DW-1:0]           proc_data;

  // One point-op lane per pixel of the memory word.
  genvar k;
  generate
    for (k = 0; k < PIXELS_PER_CLK; k++) begin : g_lane
      image_stream_pixel_op #(.THRESHOLD(THRESHOLD), .BRIGHTNESS(BRIGHTNESS)) u_op (
        .mode  (mode_q),
        .pix_i (mem_Data[24*k +: 24]),
        .pix_o (proc_data[24*k +: 24])
      );
    end
  endgenerate

  // Read gating and FIFO bookkeeping: a read may only issue if its beat is
  // guaranteed a FIFO slot, counting the read already in flight.
  always_comb begin
    pop       = (cnt_q != 2'd0) && pixel_Ready;
    occ       = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd_en     = (state_q == S_LINE) && (issue_q < BEATS) && (occ < 3'd2);
    rd_pend_d = rd_en;
    cnt_d     = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    wr_ptr_d  = wr_ptr_q ^ rd_pend_q;
    rd_ptr_d  = rd_ptr_q ^ pop;
    fifo_d    = fifo_q;
    if (rd_pend_q) fifo_d[wr_ptr_q] = proc_data;
  end

  // Frame sequencing: VSYNC -> (LINE -> HBLANK) x height -> DONE.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    line_d  = line_q;
    issue_d = issue_q;
    popc_d  = popc_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_VSYNC;
        dly_d   = '0;
        addr_d  = '0;
        line_d  = '0;
        mode_d  = mode;
      end
      S_VSYNC: if (dly_q == SD_LAST) begin
        state_d = S_LINE;
        line_d  = '0;
        issue_d = '0;
        popc_d  = '0;
      end else dly_d = dly_q + 16'd1;
      S_LINE: begin
        if (rd_en) issue_d = issue_q + 16'd1;
        if (pop) begin
          if (popc_q == LAST_BEAT) begin
            state_d = S_HBLANK;
            dly_d   = '0;
          end else popc_d = popc_q + 16'd1;
        end
      end
      S_HBLANK: if (dly_q == HD_LAST) begin
        if (line_q == LAST_LINE) state_d = S_DONE;
        else begin
          state_d = S_LINE;
          line_d  = line_q + 16'd1;
          issue_d = '0;
          popc_d  = '0;
        end
      end else dly_d = dly_q + 16'd1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rd_en) addr_d = addr_q + ADDR_WIDTH'(1);
  end

  // State register; synchronous reset also flushes the FIFO and in-flight read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      line_q    <= '0;
      issue_q   <= '0;
      popc_q    <= '0;
      addr_q    <= '0;
      mode_q    <= '0;
      rd_pend_q <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      line_q    <= line_d;
      issue_q   <= issue_d;
      popc_q    <= popc_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      rd_pend_q <= rd_pend_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_Rd_En        = rd_en;
  assign mem_Addr         = addr_q;
  assign pixel_Data       = fifo_q[rd_ptr_q];
  assign pixel_Valid      = (cnt_q != 2'd0);
  assign vertical_Pulse   = (state_q == S_VSYNC);
  assign horizontal_Pulse = (state_q == S_LINE);
  assign line_Count       = line_q;
  assign done_Flag        = (state_q == S_DONE);
endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source: W=8, H=2, PPC=2, VSYNC 4, HBLANK 3.
module tb_image_stream_source;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        mem_Rd_En;
  logic [19:0] mem_Addr;
  logic [47:0] mem_Data = '0;
  logic [47:0] pixel_Data;
  logic        pixel_Valid;
  logic        pixel_Ready = 1'b1;
  logic        vertical_Pulse, horizontal_Pulse, done_Flag;
  logic [15:0] line_Count;

  int errs = 0, checks = 0;
  int pattern_sel = 0;
  bit rand_rdy = 0;
  bit timed_out;
  logic vp_after_start;

  // monitor state
  int cyc = 0, issued = 0, accepted = 0, stall_err = 0, ostd_err = 0;
  int vs_cyc = 0, done_cnt = 0, first_valid = -1;
  bit hold_pend = 0, hp_prev = 0;
  logic [47:0] hold_data;
  logic [47:0] beats[$];
  logic [19:0] addrs[$];
  int rises[$], falls[$];
  logic [15:0] lc_rise[$];

  image_stream_source #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(2), .PIXELS_PER_CLK(2), .STARTUP_DELAY(4),
    .HSYNC_DELAY(3), .THRESHOLD(90), .BRIGHTNESS(9'sd50), .ADDR_WIDTH(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .mem_Rd_En(mem_Rd_En), .mem_Addr(mem_Addr), .mem_Data(mem_Data),
    .pixel_Data(pixel_Data), .pixel_Valid(pixel_Valid), .pixel_Ready(pixel_Ready),
    .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
    .line_Count(line_Count), .done_Flag(done_Flag)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] word_of(input logic [19:0] a);
    logic [23:0] n;
    n = {4'h0, a};
    word_of = {24'h0A0B0C + n, 24'h010203 + n};
    if (pattern_sel == 1) begin
      if (a == 0) word_of = {24'h5A5A5A, 24'h5B5A5A};
      if (a == 1) word_of = {24'h1E1E1E, 24'h1F1E1E};
      if (a == 2) word_of = {24'hFFFFFF, 24'h000000};
    end else if (pattern_sel == 2) begin
      if (a == 0) word_of = {24'hF0F0F0, 24'h101010};
      if (a == 1) word_of = {24'hCDC800, 24'hCE0001};
    end
  endfunction

  // synchronous memory: data one cycle after the strobe
  always @(posedge clk) if (mem_Rd_En) mem_Data <= word_of(mem_Addr);

  always @(posedge clk) begin
    #1;
    if (rand_rdy) pixel_Ready = ($urandom_range(0, 1) == 1);
  end

  always @(negedge clk) begin
    cyc++;
    if (hold_pend && pixel_Data !== hold_data) stall_err++;
    hold_pend = pixel_Valid && !pixel_Ready;
    hold_data = pixel_Data;
    if (mem_Rd_En) begin issued++; addrs.push_back(mem_Addr); end
    if (pixel_Valid && first_valid < 0) first_valid = cyc;
    if (pixel_Valid && pixel_Ready) begin accepted++; beats.push_back(pixel_Data); end
    if (issued - accepted > 2) ostd_err++;
    if (vertical_Pulse) vs_cyc++;
    if (done_Flag) done_cnt++;
    if (horizontal_Pulse && !hp_prev) begin rises.push_back(cyc); lc_rise.push_back(line_Count); end
    if (!horizontal_Pulse && hp_prev) falls.push_back(cyc);
    hp_prev = horizontal_Pulse;
  end

  task automatic clear_mon();
    issued = 0; accepted = 0; stall_err = 0; ostd_err = 0; vs_cyc = 0;
    done_cnt = 0; first_valid = -1; hold_pend = 0;
    beats.delete(); addrs.delete(); rises.delete(); falls.delete(); lc_rise.delete();
  endtask

  task automatic run_frame(input logic [1:0] m, input int ps);
    bit got;
    clear_mon();
    pattern_sel = ps;
    @(negedge clk); #1;
    mode = m; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; mode = 2'b00;   // latched copy must survive this change
    vp_after_start = vertical_Pulse;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (done_Flag) got = 1;
    end
    timed_out = !got;
    checks++;
    if (!got) begin errs++; $display("FAIL frame_timeout: got no done_Flag, required done within 2000 cycles"); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pixel_Data !== 48'h0) begin errs++; $display("FAIL rst_data: got %h required 0", pixel_Data); end
    checks++; if (pixel_Valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b required 0", pixel_Valid); end
    checks++; if (mem_Rd_En !== 1'b0) begin errs++; $display("FAIL rst_rden: got %b required 0", mem_Rd_En); end
    checks++; if (mem_Addr !== 20'h0) begin errs++; $display("FAIL rst_addr: got %h required 0", mem_Addr); end
    checks++; if (vertical_Pulse !== 1'b0 || horizontal_Pulse !== 1'b0) begin errs++; $display("FAIL rst_sync: got %b%b required 00", vertical_Pulse, horizontal_Pulse); end
    checks++; if (line_Count !== 16'h0 || done_Flag !== 1'b0) begin errs++; $display("FAIL rst_line_done: got %0d/%b required 0/0", line_Count, done_Flag); end
    reset = 1'b1;
  endtask

  task automatic test_pass();
    logic [47:0] exp;
    rand_rdy = 0; pixel_Ready = 1'b1;
    run_frame(2'b00, 0);
    checks++; if (vp_after_start !== 1'b1) begin errs++; $display("FAIL vsync_start: got %b required 1", vp_after_start); end
    checks++; if (vs_cyc != 4) begin errs++; $display("FAIL vsync_len: got %0d required 4", vs_cyc); end
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL pass_count: got %0d required 8", beats.size()); end
    for (int n = 0; n < 8 && n < beats.size(); n++) begin
      exp = {24'h0A0B0C + 24'(n), 24'h010203 + 24'(n)};
      checks++; if (beats[n] !== exp) begin errs++; $display("FAIL pass_beat%0d: got %h required %h", n, beats[n], exp); end
    end
    for (int n = 0; n < 8 && n < addrs.size(); n++) begin
      checks++; if (addrs[n] !== 20'(n)) begin errs++; $display("FAIL pass_addr%0d: got %0d required %0d", n, addrs[n], n); end
    end
    if (rises.size() == 2 && falls.size() >= 1) begin
      checks++; if (first_valid - rises[0] != 2) begin errs++; $display("FAIL read_latency: got %0d required 2", first_valid - rises[0]); end
      checks++; if (falls[0] - rises[0] != 6) begin errs++; $display("FAIL line_len: got %0d required 6", falls[0] - rises[0]); end
      checks++; if (rises[1] - falls[0] != 3) begin errs++; $display("FAIL hblank_len: got %0d required 3", rises[1] - falls[0]); end
      checks++; if (lc_rise[0] !== 16'd0 || lc_rise[1] !== 16'd1) begin errs++; $display("FAIL line_count: got %0d,%0d required 0,1", lc_rise[0], lc_rise[1]); end
    end else begin
      checks++; errs++; $display("FAIL line_pulses: got %0d lines required 2", rises.size());
    end
    checks++; if (done_cnt != 1) begin errs++; $display("FAIL done_pulse: got %0d required 1", done_cnt); end
  endtask

  task automatic test_threshold();
    run_frame(2'b01, 1);
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL thr_count: got %0d required 8", beats.size()); end
    else begin
      checks++; if (beats[0] !== 48'h000000_FFFFFF) begin errs++; $display("FAIL thr_270_271: got %h required 000000ffffff", beats[0]); end
      checks++; if (beats[1] !== 48'h0) begin errs++; $display("FAIL thr_low: got %h required 0", beats[1]); end
      checks++; if (beats[2] !== 48'hFFFFFF_000000) begin errs++; $display("FAIL thr_ext: got %h required ffffff000000", beats[2]); end
      checks++; if (beats[3] !== 48'h0) begin errs++; $display("FAIL thr_w3: got %h required 0", beats[3]); end
    end
  endtask

  task automatic test_invert();
    run_frame(2'b10, 0);
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL inv_count: got %0d required 8", beats.size()); end
    else begin
      checks++; if (beats[0] !== 48'hF5F4F3_FEFDFC) begin errs++; $display("FAIL inv_b0: got %h required f5f4f3fefdfc", beats[0]); end
      checks++; if (beats[7] !== 48'hF5F4EC_FEFDF5) begin errs++; $display("FAIL inv_b7: got %h required f5f4ecfefdf5", beats[7]); end
    end
  endtask

  task automatic test_brightness();
    logic [47:0] e0, e1, e2;
`ifdef IMG_BRIGHTNESS_EN
    e0 = 48'hFFFFFF_424242; e1 = 48'hFFFA32_FF3233; e2 = 48'h3C3D40_333437;
`else
    e0 = 48'hF0F0F0_101010; e1 = 48'hCDC800_CE0001; e2 = 48'h0A0B0E_010205;
`endif
    run_frame(2'b11, 2);
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL bri_count: got %0d required 8", beats.size()); end
    else begin
      checks++; if (beats[0] !== e0) begin errs++; $display("FAIL bri_b0: got %h required %h", beats[0], e0); end
      checks++; if (beats[1] !== e1) begin errs++; $display("FAIL bri_b1: got %h required %h", beats[1], e1); end
      checks++; if (beats[2] !== e2) begin errs++; $display("FAIL bri_b2: got %h required %h", beats[2], e2); end
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] exp;
    rand_rdy = 1;
    run_frame(2'b00, 0);
    rand_rdy = 0; pixel_Ready = 1'b1;
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL bp_count: got %0d required 8", beats.size()); end
    for (int n = 0; n < 8 && n < beats.size(); n++) begin
      exp = {24'h0A0B0C + 24'(n), 24'h010203 + 24'(n)};
      checks++; if (beats[n] !== exp) begin errs++; $display("FAIL bp_beat%0d: got %h required %h", n, beats[n], exp); end
    end
    checks++; if (stall_err != 0) begin errs++; $display("FAIL bp_stable: got %0d changes required 0", stall_err); end
    checks++; if (ostd_err != 0) begin errs++; $display("FAIL bp_outstanding: got %0d cycles over 2 required 0", ostd_err); end
  endtask

  task automatic test_mid_reset();
    bit got;
    clear_mon();
    pattern_sel = 0; pixel_Ready = 1'b1;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk); #1;
      if (beats.size() >= 6) got = 1;
    end
    checks++; if (!got) begin errs++; $display("FAIL mid_reach: got %0d beats required 6", beats.size()); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (pixel_Data !== 48'h0 || pixel_Valid !== 1'b0 || mem_Rd_En !== 1'b0 || mem_Addr !== 20'h0)
      begin errs++; $display("FAIL mid_rst_data: got %h/%b/%b/%h required 0/0/0/0", pixel_Data, pixel_Valid, mem_Rd_En, mem_Addr); end
    checks++; if (vertical_Pulse !== 1'b0 || horizontal_Pulse !== 1'b0 || line_Count !== 16'h0 || done_Flag !== 1'b0)
      begin errs++; $display("FAIL mid_rst_ctrl: got %b/%b/%0d/%b required 0/0/0/0", vertical_Pulse, horizontal_Pulse, line_Count, done_Flag); end
    reset = 1'b1;
    run_frame(2'b00, 0);
    checks++; if (beats.size() != 8) begin errs++; $display("FAIL replay_count: got %0d required 8", beats.size()); end
    else begin
      checks++; if (beats[0] !== 48'h0A0B0C_010203) begin errs++; $display("FAIL replay_b0: got %h required 0a0b0c010203", beats[0]); end
    end
    checks++; if (addrs.size() == 0 || addrs[0] !== 20'h0) begin errs++; $display("FAIL replay_addr: got first addr mismatch, required 0"); end
  endtask

  task automatic test_done_start();
    bit got;
    pattern_sel = 0;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (done_Flag) got = 1;
    end
    checks++; if (!got) begin errs++; $display("FAIL ds_timeout: got no done_Flag required one"); end
    start = 1'b1;                      // presented during DONE
    @(negedge clk); #1;
    checks++; if (vertical_Pulse !== 1'b0) begin errs++; $display("FAIL done_start_ignored: got vsync %b required 0", vertical_Pulse); end
    @(negedge clk); #1;
    start = 1'b0;
    checks++; if (vertical_Pulse !== 1'b1) begin errs++; $display("FAIL idle_start_taken: got vsync %b required 1", vertical_Pulse); end
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk); #1;
      if (done_Flag) got = 1;
    end
    checks++; if (!got) begin errs++; $display("FAIL ds_timeout2: got no done_Flag required one"); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_threshold();
    test_invert();
    test_brightness();
    test_backpressure();
    test_mid_reset();
    test_done_start();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
